dmem_responder: RTL

- Data-memory responder serving the MEMORY pipeline stage's load/store requests over a req/ready handshake.
- It is the slave end of the MEMORY stage's memread/memwrite/alu_result/rdata2out interface.
- Adds a configurable wait-state latency, so the pipeline stall logic can be exercised against a multi-cycle memory.
- Word-addressed storage, byte addresses at the port, alignment checking.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_wait_counter.sv | 34 +++
 rtl/dmem_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Word-addressed storage behind a byte-addressed request port.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_LSB   = $clog2(WORD_BYTES);
  localparam int unsigned CNT_W      = 4;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable wait-state down-counter; saturates at zero and flags it.
module dmem_wait_counter
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEMORY stage: req/ready handshake with a
// configurable number of wait states, word storage and alignment checking.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int unsigned IdxW  = idx_width(DEPTH_WORDS);
  localparam int unsigned AddrW = IdxW + ADDR_LSB;
  localparam logic [CNT_W-1:0] WaitLoad =
      (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  // Storage has no reset; it starts out zeroed and survives rst.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0};

  state_e            state_q;
  logic              we_q;
  logic [AddrW-1:0]  addr_q;
  logic [31:0]       wdata_q;
  logic              ready_q;
  logic              err_q;
  logic              busy_q;
  logic [31:0]       rdata_q;

  logic              misaligned;
  logic [IdxW-1:0]   idx;
  logic              mem_we;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:AddrW];

  assign misaligned = (addr_q[ADDR_LSB-1:0] != '0);
  assign idx        = addr_q[ADDR_LSB +: IdxW];
  assign mem_we     = (state_q == StResp) && we_q && !misaligned;
  assign cnt_load   = (state_q == StIdle) && req;
  assign cnt_dec    = (state_q == StWait);

  dmem_wait_counter u_wait_counter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(WaitLoad),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  // The access happens on the edge leaving StResp, so ready/err/rdata appear
  // together one cycle later while the FSM is already back in StIdle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= req;
          if (req) begin
            we_q    <= we;
            addr_q  <= addr[AddrW-1:0];
            wdata_q <= wdata;
            state_q <= (WAIT_STATES > 0) ? StWait : StResp;
          end
        end
        StWait: begin
          if (cnt_zero) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          ready_q <= 1'b1;
          err_q   <= misaligned;
          if (!we_q && !misaligned) begin
            rdata_q <= mem_q[idx];
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign rdata = rdata_q;

endmodule
